// File: rtl/tlcd_pkg.sv
// Shared constants and helpers for the HD44780-style LCD bus monitor.
package tlcd_pkg;

  // Command-class masks; the highest set bit of a command selects its class.
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_CLEAR = 8'h01;

  // DDRAM line bases and last addresses of each 40-character line.
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_END  = 7'h27;
  localparam logic [6:0] LINE2_END  = 7'h67;

  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_t;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_sample_t;

  // Next DDRAM address; the two lines form one 80-character ring.
  function automatic logic [6:0] ddram_step(input logic [6:0] ac, input logic id);
    logic [6:0] nxt;
    if (id) begin
      if (ac == LINE1_END)      nxt = LINE2_BASE;
      else if (ac == LINE2_END) nxt = LINE1_BASE;
      else                      nxt = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)      nxt = LINE2_END;
      else if (ac == LINE2_BASE) nxt = LINE1_END;
      else                       nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tlcd_bus_sampler.sv
// Two-stage sampler of the LCD bus; flags a transfer on the falling edge of E.
module tlcd_bus_sampler
  import tlcd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_e,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [7:0] i_data,
  output logic       o_xfer,
  output logic       o_rs,
  output logic       o_rw,
  output logic [7:0] o_data
);

  bus_sample_t r_s1;
  bus_sample_t r_s2;

  // Shift the bus through s1 then s2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= '{e: i_e, rs: i_rs, rw: i_rw, data: i_data};
      r_s2 <= r_s1;
    end
  end

  // s2 still holds the fields captured while E was high.
  assign o_xfer = ~r_s1.e & r_s2.e;
  assign o_rs   = r_s2.rs;
  assign o_rw   = r_s2.rw;
  assign o_data = r_s2.data;

endmodule

// File: rtl/tlcd_bus_monitor.sv
// Passive LCD bus monitor: shadows the visible DDRAM, tracks the address
// counter and mode bits, and reports CGRAM writes.
module tlcd_bus_monitor
  import tlcd_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       TLCD_E,
  input  logic       TLCD_RS,
  input  logic       TLCD_RW,
  input  logic [7:0] TLCD_DATA,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic [6:0] AC,
  output logic       CG_MODE,
  output logic       DISP_ON,
  output logic       BUSY,
  output logic       CG_WR,
  output logic [5:0] CG_ADDR,
  output logic [7:0] CG_DATA,
  output logic       OVERRUN,
  output logic       RD_ERR
);

  logic       w_xfer;
  logic       w_rs;
  logic       w_rw;
  logic [7:0] w_data;

  clr_state_t r_state;
  logic [4:0] r_clr_idx;
  logic [7:0] r_shadow [32];
  logic [6:0] r_ac;
  logic       r_id;
  logic       r_cg_mode;
  logic       r_disp_on;
  logic       r_busy;
  logic       r_cg_wr;
  logic [5:0] r_cg_addr;
  logic [7:0] r_cg_data;
  logic       r_overrun;
  logic       r_rd_err;
  logic [7:0] r_rd_data;

  tlcd_bus_sampler u_sampler (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .i_e     (TLCD_E),
    .i_rs    (TLCD_RS),
    .i_rw    (TLCD_RW),
    .i_data  (TLCD_DATA),
    .o_xfer  (w_xfer),
    .o_rs    (w_rs),
    .o_rw    (w_rw),
    .o_data  (w_data)
  );

  // Transfer decode, shadow writes and the clear sequencer.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state   <= CLR_IDLE;
      r_clr_idx <= '0;
      r_shadow  <= '{default: SPACE};
      r_ac      <= '0;
      r_id      <= 1'b1;
      r_cg_mode <= 1'b0;
      r_disp_on <= 1'b0;
      r_busy    <= 1'b0;
      r_cg_wr   <= 1'b0;
      r_cg_addr <= '0;
      r_cg_data <= '0;
      r_overrun <= 1'b0;
      r_rd_err  <= 1'b0;
    end else begin
      r_cg_wr <= 1'b0;
      case (r_state)
        CLR_CLEAR: begin
          r_shadow[r_clr_idx] <= SPACE;
          r_clr_idx           <= r_clr_idx + 5'd1;
          if (w_xfer) r_overrun <= 1'b1;
          if (r_clr_idx == 5'd31) begin
            r_ac      <= LINE1_BASE;
            r_cg_mode <= 1'b0;
            r_id      <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= CLR_IDLE;
          end
        end
        default: begin
          if (w_xfer) begin
            if (w_rw) begin
              r_rd_err <= 1'b1;
            end else if (!w_rs) begin
              if ((w_data & CMD_DDRAM) != '0) begin
                r_ac      <= w_data[6:0];
                r_cg_mode <= 1'b0;
              end else if ((w_data & CMD_CGRAM) != '0) begin
                r_ac      <= {1'b0, w_data[5:0]};
                r_cg_mode <= 1'b1;
              end else if ((w_data & (CMD_FUNC | CMD_SHIFT)) != '0) begin
                r_ac <= r_ac;
              end else if ((w_data & CMD_DISP) != '0) begin
                r_disp_on <= w_data[2];
              end else if ((w_data & CMD_ENTRY) != '0) begin
                r_id <= w_data[1];
              end else if ((w_data & CMD_HOME) != '0) begin
                r_ac      <= LINE1_BASE;
                r_cg_mode <= 1'b0;
              end else if ((w_data & CMD_CLEAR) != '0) begin
                r_state   <= CLR_CLEAR;
                r_clr_idx <= '0;
                r_busy    <= 1'b1;
              end
            end else if (r_cg_mode) begin
              r_cg_wr   <= 1'b1;
              r_cg_addr <= r_ac[5:0];
              r_cg_data <= w_data;
              r_ac      <= {1'b0, (r_id ? r_ac[5:0] + 6'd1 : r_ac[5:0] - 6'd1)};
            end else begin
              // Only the first 16 columns of each line are shadowed.
              if (r_ac[6:4] == 3'b000)      r_shadow[{1'b0, r_ac[3:0]}] <= w_data;
              else if (r_ac[6:4] == 3'b100) r_shadow[{1'b1, r_ac[3:0]}] <= w_data;
              r_ac <= ddram_step(r_ac, r_id);
            end
          end
        end
      endcase
    end
  end

  // Registered read port; a same-edge write is seen one cycle later.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_rd_data <= '0;
    else         r_rd_data <= r_shadow[RD_ADDR];
  end

  assign RD_DATA = r_rd_data;
  assign AC      = r_ac;
  assign CG_MODE = r_cg_mode;
  assign DISP_ON = r_disp_on;
  assign BUSY    = r_busy;
  assign CG_WR   = r_cg_wr;
  assign CG_ADDR = r_cg_addr;
  assign CG_DATA = r_cg_data;
  assign OVERRUN = r_overrun;
  assign RD_ERR  = r_rd_err;

endmodule

// File: tb/tb_tlcd_bus_monitor.sv
// Bench for tlcd_bus_monitor: directed table, clear/reset sequences and
// randomized transfers checked against a behavioural model.
module tb_tlcd_bus_monitor;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       TLCD_E = 1'b0;
  logic       TLCD_RS = 1'b0;
  logic       TLCD_RW = 1'b0;
  logic [7:0] TLCD_DATA = '0;
  logic [4:0] RD_ADDR = '0;
  logic [7:0] RD_DATA;
  logic [6:0] AC;
  logic       CG_MODE, DISP_ON, BUSY, CG_WR, OVERRUN, RD_ERR;
  logic [5:0] CG_ADDR;
  logic [7:0] CG_DATA;

  tlcd_bus_monitor dut (
    .CLK(CLK), .RESETN(RESETN), .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS),
    .TLCD_RW(TLCD_RW), .TLCD_DATA(TLCD_DATA), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .AC(AC), .CG_MODE(CG_MODE), .DISP_ON(DISP_ON),
    .BUSY(BUSY), .CG_WR(CG_WR), .CG_ADDR(CG_ADDR), .CG_DATA(CG_DATA),
    .OVERRUN(OVERRUN), .RD_ERR(RD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int a; int d; } cgw_t;
  cgw_t exp_cg[$];
  cgw_t got_cg[$];

  int m_sh [32];
  int m_ac;
  bit m_id, m_cg, m_disp, m_ovr, m_rde;

  function automatic void m_fill();
    for (int i = 0; i < 32; i++) m_sh[i] = 'h20;
  endfunction

  function automatic void m_reset();
    m_fill();
    m_ac = 0; m_id = 1; m_cg = 0; m_disp = 0; m_ovr = 0; m_rde = 0;
  endfunction

  // The two lines are one 80-position ring: positions 0-39 then 40-79.
  function automatic int m_next_ddram(input int ac, input bit id);
    int pos;
    if (ac <= 'h27 || (ac >= 'h40 && ac <= 'h67)) begin
      pos = (ac >= 'h40) ? 40 + ac - 'h40 : ac;
      pos = id ? (pos + 1) % 80 : (pos + 79) % 80;
      return (pos >= 40) ? 'h40 + pos - 40 : pos;
    end
    return id ? (ac + 1) % 128 : (ac + 127) % 128;
  endfunction

  function automatic void m_xfer(input bit rs, input bit rw, input int d);
    cgw_t e;
    if (rw) begin
      m_rde = 1;
    end else if (!rs) begin
      if (d >= 128)     begin m_ac = d - 128; m_cg = 0; end
      else if (d >= 64) begin m_ac = d - 64;  m_cg = 1; end
      else if (d >= 16) begin end
      else if (d >= 8)  m_disp = bit'((d / 4) % 2);
      else if (d >= 4)  m_id = bit'((d / 2) % 2);
      else if (d >= 2)  begin m_ac = 0; m_cg = 0; end
      else if (d == 1)  begin m_fill(); m_ac = 0; m_cg = 0; m_id = 1; end
    end else if (m_cg) begin
      e.a = m_ac; e.d = d;
      exp_cg.push_back(e);
      m_ac = m_id ? (m_ac + 1) % 64 : (m_ac + 63) % 64;
    end else begin
      if (m_ac < 16) m_sh[m_ac] = d;
      else if (m_ac >= 'h40 && m_ac < 'h50) m_sh[m_ac - 'h40 + 16] = d;
      m_ac = m_next_ddram(m_ac, m_id);
    end
  endfunction

  // ---------------- bus helpers ----------------
  always @(negedge CLK) begin
    cgw_t e;
    if (CG_WR === 1'b1) begin
      e.a = int'(CG_ADDR); e.d = int'(CG_DATA);
      got_cg.push_back(e);
    end
  end

  task automatic bus_write(input bit rs, input bit rw, input int d);
    @(negedge CLK);
    TLCD_RS = rs; TLCD_RW = rw; TLCD_DATA = 8'(d); TLCD_E = 1'b1;
    repeat (2) @(negedge CLK);
    TLCD_E = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic start_clear();
    @(negedge CLK);
    TLCD_RS = 1'b0; TLCD_RW = 1'b0; TLCD_DATA = 8'h01; TLCD_E = 1'b1;
    repeat (2) @(negedge CLK);
    TLCD_E = 1'b0;
  endtask

  task automatic rd(input int idx, output int val);
    @(negedge CLK); RD_ADDR = 5'(idx);
    @(negedge CLK); val = int'(RD_DATA);
  endtask

  task automatic check_shadow(input string tag);
    @(negedge CLK); RD_ADDR = 5'd0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      chk($sformatf("%s shadow[%0d]", tag, i), RD_DATA, m_sh[i]);
      RD_ADDR = 5'(i + 1);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " AC"}, AC, m_ac);
    chk({tag, " CG_MODE"}, CG_MODE, m_cg);
    chk({tag, " DISP_ON"}, DISP_ON, m_disp);
    chk({tag, " RD_ERR"}, RD_ERR, m_rde);
    chk({tag, " OVERRUN"}, OVERRUN, m_ovr);
    chk({tag, " BUSY"}, BUSY, 0);
  endtask

  task automatic check_cg(input string tag);
    chk({tag, " CG_WR count"}, got_cg.size(), exp_cg.size());
    for (int i = 0; i < got_cg.size() && i < exp_cg.size(); i++) begin
      chk({tag, " CG_ADDR"}, got_cg[i].a, exp_cg[i].a);
      chk({tag, " CG_DATA"}, got_cg[i].d, exp_cg[i].d);
    end
    got_cg.delete(); exp_cg.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rs; bit rw; int d;
    int ac; bit cg; bit disp; bit cgw; int cga; int cgd;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, cnt, t;
    bit rs, rw;
    int d, r, k;

    //        rs rw data   ac     cg disp cgw cga    cgd
    tbl.push_back('{0, 0, 'h80, 'h00, 0, 0, 0, 0,     0});
    tbl.push_back('{0, 0, 'h06, 'h00, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 0, 'h41, 'h01, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 0, 'h42, 'h02, 0, 0, 0, 0,     0});
    tbl.push_back('{0, 0, 'hA7, 'h27, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 0, 'h55, 'h40, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 0, 'h56, 'h41, 0, 0, 0, 0,     0});
    tbl.push_back('{0, 0, 'h78, 'h38, 1, 0, 0, 0,     0});
    tbl.push_back('{1, 0, 'h1F, 'h39, 1, 0, 1, 'h38, 'h1F});
    tbl.push_back('{1, 0, 'h0E, 'h3A, 1, 0, 1, 'h39, 'h0E});
    tbl.push_back('{0, 0, 'h80, 'h00, 0, 0, 0, 0,     0});
    tbl.push_back('{0, 0, 'h04, 'h00, 0, 0, 0, 0,     0});
    tbl.push_back('{0, 0, 'h80, 'h00, 0, 0, 0, 0,     0});
    tbl.push_back('{1, 0, 'h30, 'h67, 0, 0, 0, 0,     0});
    tbl.push_back('{0, 0, 'h0C, 'h67, 0, 1, 0, 0,     0});
    tbl.push_back('{0, 0, 'h3F, 'h67, 0, 1, 0, 0,     0});
    tbl.push_back('{0, 1, 'h01, 'h67, 0, 1, 0, 0,     0});
    tbl.push_back('{0, 0, 'h06, 'h67, 0, 1, 0, 0,     0});
    tbl.push_back('{1, 0, 'h58, 'h00, 0, 1, 0, 0,     0});
    tbl.push_back('{0, 0, 'h08, 'h00, 0, 0, 0, 0,     0});

    // Reset values
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset RD_DATA", RD_DATA, 0);
    chk("reset AC", AC, 0);
    chk("reset CG_ADDR", CG_ADDR, 0);
    chk("reset CG_DATA", CG_DATA, 0);
    chk("reset CG_WR", CG_WR, 0);
    chk("reset BUSY", BUSY, 0);
    chk("reset CG_MODE", CG_MODE, 0);
    chk("reset DISP_ON", DISP_ON, 0);
    chk("reset OVERRUN", OVERRUN, 0);
    chk("reset RD_ERR", RD_ERR, 0);
    RESETN = 1'b1;
    m_reset();
    check_shadow("reset");

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      bus_write(tbl[i].rs, tbl[i].rw, tbl[i].d);
      m_xfer(tbl[i].rs, tbl[i].rw, tbl[i].d);
      chk($sformatf("tbl%0d AC", i), AC, tbl[i].ac);
      chk($sformatf("tbl%0d CG_MODE", i), CG_MODE, tbl[i].cg);
      chk($sformatf("tbl%0d DISP_ON", i), DISP_ON, tbl[i].disp);
      chk($sformatf("tbl%0d BUSY", i), BUSY, 0);
      chk($sformatf("tbl%0d CG_WR count", i), got_cg.size(), tbl[i].cgw ? 1 : 0);
      if (tbl[i].cgw && got_cg.size() >= 1) begin
        chk($sformatf("tbl%0d CG_ADDR", i), got_cg[0].a, tbl[i].cga);
        chk($sformatf("tbl%0d CG_DATA", i), got_cg[0].d, tbl[i].cgd);
      end
      got_cg.delete(); exp_cg.delete();
    end
    chk("tbl RD_ERR sticky", RD_ERR, 1);
    rd(0, v);  chk("tbl shadow[0]", v, 'h30);
    rd(1, v);  chk("tbl shadow[1]", v, 'h42);
    rd(16, v); chk("tbl shadow[16]", v, 'h56);
    rd(7, v);  chk("tbl shadow[7]", v, 'h20);
    check_shadow("tbl");

    // Clear: BUSY width
    start_clear();
    cnt = 0;
    repeat (60) begin
      @(negedge CLK);
      if (BUSY === 1'b1) cnt++;
    end
    chk("clear BUSY cycles", cnt, 32);
    m_xfer(0, 0, 1);
    check_state("clear");
    check_shadow("clear");

    // Clear with a transfer while BUSY
    bus_write(1, 0, 'h61);
    m_xfer(1, 0, 'h61);
    start_clear();
    repeat (3) @(negedge CLK);
    chk("overrun BUSY early", BUSY, 1);
    bus_write(1, 0, 'h99);
    t = 0;
    while (BUSY !== 1'b0 && t < 60) begin @(negedge CLK); t++; end
    chk("overrun clear finished", BUSY, 0);
    m_xfer(0, 0, 1);
    m_ovr = 1;
    check_state("overrun");
    check_cg("overrun");
    check_shadow("overrun");

    // Reset in the middle of a clear
    bus_write(0, 0, 'hC4);
    bus_write(1, 0, 'h7E);
    start_clear();
    t = 0;
    while (BUSY !== 1'b1 && t < 10) begin @(negedge CLK); t++; end
    chk("midclear BUSY seen", BUSY, 1);
    repeat (10) @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    chk("midclear BUSY in reset", BUSY, 0);
    RESETN = 1'b1;
    m_reset();
    got_cg.delete(); exp_cg.delete();
    check_state("midclear");
    check_shadow("midclear");

    // Randomized transfers against the model
    for (int n = 0; n < 200; n++) begin
      rs = 0; rw = 0;
      r = $urandom_range(0, 99);
      if (r < 40) begin
        rs = 1; d = $urandom_range(0, 255);
      end else if (r < 44) begin
        d = $urandom_range(128, 255);
      end else if (r < 55) begin
        k = $urandom_range(0, 79);
        d = 'h80 + ((k < 40) ? k : 'h40 + k - 40);
      end else if (r < 63) begin
        d = $urandom_range(64, 127);
      end else if (r < 73) begin
        d = $urandom_range(4, 7);
      end else if (r < 83) begin
        d = $urandom_range(8, 15);
      end else if (r < 88) begin
        d = $urandom_range(2, 3);
      end else if (r < 93) begin
        d = (r == 88) ? 0 : $urandom_range(16, 63);
      end else if (r < 97) begin
        rw = 1; rs = 1'($urandom_range(0, 1)); d = $urandom_range(0, 255);
      end else begin
        d = 1;
      end
      bus_write(rs, rw, d);
      if (!rs && !rw && d == 1) repeat (36) @(negedge CLK);
      m_xfer(rs, rw, d);
      check_state($sformatf("rnd%0d", n));
      check_cg($sformatf("rnd%0d", n));
      if (n % 25 == 24) check_shadow($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tlcd_bus_monitor.md
TLCD_BUS_MONITOR -- requirements
Module: tlcd_bus_monitor

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-low.
REQ-002 CLK  in  1  system clock, 1 MHz, same domain as the LCD bus driver.
REQ-003 RESETN  in  1  asynchronous active-low reset.
REQ-004 TLCD_E  in  1  LCD enable; the transfer completes on its falling edge.
REQ-005 TLCD_RS  in  1  0 = command, 1 = data.
REQ-006 TLCD_RW  in  1  0 = write, 1 = read.
REQ-007 TLCD_DATA  in  8  bus data.
REQ-008 RD_ADDR  in  5  shadow index: 0-15 is line 1, 16-31 is line 2.
REQ-009 RD_DATA  out  8  shadow character at RD_ADDR, registered.
REQ-010 AC  out  7  current address counter.
REQ-011 CG_MODE  out  1  1 = address counter targets CGRAM.
REQ-012 DISP_ON  out  1  D bit from the last display-control command.
REQ-013 BUSY  out  1  clear operation in progress.
REQ-014 CG_WR  out  1  one-cycle pulse for each CGRAM data write; CG_ADDR (6) and CG_DATA (8) are valid with it.
REQ-015 OVERRUN  out  1  sticky flag: a transfer arrived while BUSY.
REQ-016 RD_ERR  out  1  sticky flag: a transfer was seen with TLCD_RW=1.

Function
REQ-017 Input sampling: all bus inputs pass through two register stages, s1 then s2.
REQ-018 Transfer detection: a transfer occurs when s1.E=0 and s2.E=1.
  - RS, RW and DATA are taken from s2, i.e. as sampled while E was still high.
  - All state updates take effect at the CLK edge after the edge at which E is first sampled low.
REQ-019 RW=1 transfers: set RD_ERR; no other effect.
REQ-020 Command decode (RS=0), highest set bit wins:
  - 0x80-0xFF: AC = DATA[6:0], CG_MODE=0.
  - 0x40-0x7F: AC = DATA[5:0], CG_MODE=1.
  - 0x20-0x3F: ignored.
  - 0x10-0x1F: ignored.
  - 0x08-0x0F: DISP_ON = DATA[2].
  - 0x04-0x07: ID = DATA[1].
  - 0x02-0x03: AC=0, CG_MODE=0.
  - 0x01: start clear.
  - 0x00: ignored.
REQ-021 Data write (RS=1), CG_MODE=0:
  - AC 0x00-0x0F writes shadow[AC].
  - AC 0x40-0x4F writes shadow[AC-0x40+16].
  - Any other AC drops the write.
  - Then AC steps.
REQ-022 Data write (RS=1), CG_MODE=1:
  - Pulse CG_WR with CG_ADDR=AC[5:0] and CG_DATA=DATA.
  - Then AC steps within 0x00-0x3F, wrapping.
REQ-023 DDRAM step, ID=1: 0x27 goes to 0x40, 0x67 goes to 0x00, otherwise +1.
REQ-024 DDRAM step, ID=0: 0x00 goes to 0x67, 0x40 goes to 0x27, otherwise -1.
REQ-025 Clear state machine, states IDLE and CLEAR:
  - IDLE to CLEAR on command 0x01.
  - CLEAR writes 0x20 to one shadow entry per cycle, index 0 to 31.
  - After index 31: AC=0, CG_MODE=0, ID=1, then back to IDLE.
  - BUSY is high for exactly 32 cycles.
REQ-026 A transfer detected while BUSY is dropped and sets OVERRUN.
REQ-027 Read port: RD_DATA = shadow[RD_ADDR], registered with 1-cycle latency.
  - A same-cycle write to the same index returns the old value.

Reset
REQ-028 Reset values:
  - shadow entries all 0x20; AC=0; ID=1.
  - CG_MODE, DISP_ON, BUSY, CG_WR, OVERRUN, RD_ERR all 0.
  - CG_ADDR, CG_DATA and RD_DATA all 0.
  - Sampler stages reset to 0.
REQ-029 Reset asserted during CLEAR aborts the clear; all state takes the REQ-028 reset values.

Structure
REQ-030 Shared package tlcd_pkg holds:
  - command-class masks;
  - DDRAM line bases 0x00 and 0x40;
  - wrap points 0x27 and 0x67;
  - SPACE = 0x20;
  - clear-state encodings.
REQ-031 Sub-module tlcd_bus_sampler holds the two sampler stages and outputs a one-cycle xfer pulse with the latched RS, RW and DATA.

Verification
REQ-032 Cursor write: commands 0x80 then 0x06, then data 0x41 and 0x42 -> shadow[0]=0x41, shadow[1]=0x42, AC=0x02.
REQ-033 Line wrap: command 0xA7, then data 0x55 with ID=1 -> write dropped, AC=0x40; next data 0x56 -> shadow[16]=0x56, AC=0x41.
REQ-034 Clear: command 0x01 -> BUSY high for 32 cycles; a transfer during BUSY sets OVERRUN; afterwards all RD_DATA reads return 0x20 and AC=0.
REQ-035 CGRAM: commands 0x78, then data 0x1F and 0x0E -> CG_WR pulses with (0x38, 0x1F) then (0x39, 0x0E), CG_MODE=1; command 0x80 -> CG_MODE=0.
REQ-036 Decrement: commands 0x04 then 0x80, then data 0x30 -> shadow[0]=0x30, AC=0x67; command 0x0C -> DISP_ON=1.
REQ-037 Reset mid-clear: RESETN low at clear cycle 10 -> BUSY=0 and every shadow entry reads 0x20.
